// File: rtl/qpsk_timing_tracker_pkg.sv
// Shared types and limits for the QPSK timing tracker.
// The optional error statistics are enabled with QPSK_TIMING_STATS_EN.
package qpsk_timing_pkg;

    localparam int unsigned REC_W = 16;

    // Error saturation limits, applied to the 17-bit signed difference
    localparam logic signed [16:0] ERR_SAT_POS = 17'sd32767;
    localparam logic signed [16:0] ERR_SAT_NEG = -17'sd32767;

    // Reset values of the running min/max statistics
    localparam logic signed [15:0] STAT_MIN_INIT = 16'sh7FFF;
    localparam logic signed [15:0] STAT_MAX_INIT = 16'sh8000;

    typedef struct packed {
        logic [REC_W-1:0] interval;
        logic [REC_W-1:0] error;
    } qpsk_rec_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIMED,
        ST_TRACK
    } trk_state_t;

    // Clamp a 17-bit signed difference into the 16-bit error field
    function automatic logic [15:0] sat16(input logic signed [16:0] x);
        logic signed [16:0] y;
        y = x;
        if (x > ERR_SAT_POS) y = ERR_SAT_POS;
        if (x < ERR_SAT_NEG) y = ERR_SAT_NEG;
        return y[15:0];
    endfunction

endpackage

// File: rtl/qpsk_timing_tracker_if.sv
// Record read port: head-of-FIFO record with valid/ready handshake.
interface qpsk_timing_tracker_if;

    logic [15:0] rec_interval;
    logic [15:0] rec_error;
    logic        rec_valid;
    logic        rec_ready;

    modport master (
        output rec_interval,
        output rec_error,
        output rec_valid,
        input  rec_ready
    );

    modport slave (
        input  rec_interval,
        input  rec_error,
        input  rec_valid,
        output rec_ready
    );

endinterface

// File: rtl/qpsk_timing_tracker_rec_fifo.sv
// Small synchronous FIFO of interval/error records.
// A push while full is accepted only if a pop happens in the same cycle.
module qpsk_rec_fifo
    import qpsk_timing_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  logic      pop,
    input  qpsk_rec_t din,
    output qpsk_rec_t dout,
    output logic      full,
    output logic      empty
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    qpsk_rec_t       mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW:0]     count;
    logic            push_ok_c;
    logic            pop_ok_c;

    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign pop_ok_c  = pop && !empty;
    assign push_ok_c = push && (!full || pop_ok_c);
    assign dout      = mem[rd_ptr];

    // Storage, pointers and occupancy; depth is a power of two so pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok_c) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok_c && !pop_ok_c) begin
                count <= count + (AW+1)'(1);
            end else if (pop_ok_c && !push_ok_c) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/qpsk_timing_tracker.sv
// QPSK timing tracker: measures CIC-pulse count per capture interval,
// tracks lock against the nominal rate and queues {interval, error} records.
// Optional feature macro: QPSK_TIMING_STATS_EN adds err_min/err_max outputs.
module qpsk_timing_tracker
    import qpsk_timing_pkg::*;
#(
    parameter int unsigned NOMINAL    = 39062,
    parameter int unsigned LOCK_TOL   = 4,
    parameter int unsigned LOCK_COUNT = 3,
    parameter int unsigned TIMEOUT    = 16777215,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [15:0]                cic_pulse_counter,
    input  logic                       write,
    qpsk_timing_tracker_if.master      rec_if,
    output logic                       locked,
    output logic                       lost,
    output logic                       overflow
`ifdef QPSK_TIMING_STATS_EN
    ,
    output logic signed [15:0]         err_min,
    output logic signed [15:0]         err_max
`endif
);

    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    localparam int unsigned LC_W = $clog2(LOCK_COUNT + 1);

    trk_state_t        state;
    logic              write_q;
    logic              cap_c;
    logic              cap_s1;
    logic              cap_s2;
    logic [15:0]       cnt_s2;
    logic [15:0]       prev;
    qpsk_rec_t         rec_s3;
    logic              push_s3;
    logic [TO_W-1:0]   idle_cnt;
    logic [LC_W-1:0]   tol_cnt;

    logic [15:0]       interval_c;
    logic signed [16:0] diff_c;
    logic [15:0]       err_c;
    logic [15:0]       err_abs_c;
    logic              in_tol_c;
    logic              pop_c;
    logic              push_acc_c;
    logic              full;
    logic              empty;
    qpsk_rec_t         head;

    assign cap_c      = write && !write_q;
    assign interval_c = cnt_s2 - prev;
    assign diff_c     = $signed({1'b0, interval_c}) - $signed(17'(NOMINAL));
    assign err_c      = sat16(diff_c);
    assign err_abs_c  = rec_s3.error[15] ? (~rec_s3.error + 16'd1) : rec_s3.error;
    assign in_tol_c   = (err_abs_c <= 16'(LOCK_TOL));
    assign pop_c      = rec_if.rec_valid && rec_if.rec_ready;
    assign push_acc_c = push_s3 && (!full || pop_c);

    // Edge detect and count capture pipeline (flag at N, count at N+1)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q <= 1'b0;
            cap_s1  <= 1'b0;
            cap_s2  <= 1'b0;
            cnt_s2  <= '0;
        end else begin
            write_q <= write;
            cap_s1  <= cap_c;
            cap_s2  <= cap_s1;
            if (cap_s1) begin
                cnt_s2 <= cic_pulse_counter;
            end
        end
    end

    // Tracking FSM: interval/error at N+2, lock update with the push at N+3, timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            prev     <= '0;
            rec_s3   <= '0;
            push_s3  <= 1'b0;
            idle_cnt <= '0;
            tol_cnt  <= '0;
            locked   <= 1'b0;
            lost     <= 1'b0;
        end else begin
            push_s3 <= 1'b0;
            if (push_s3) begin
                if (in_tol_c) begin
                    if (tol_cnt != LC_W'(LOCK_COUNT)) begin
                        tol_cnt <= tol_cnt + LC_W'(1);
                    end
                    if (tol_cnt >= LC_W'(LOCK_COUNT - 1)) begin
                        locked <= 1'b1;
                    end
                end else begin
                    tol_cnt <= '0;
                    locked  <= 1'b0;
                end
            end
            case (state)
                ST_IDLE: begin
                    idle_cnt <= '0;
                    if (cap_s2) begin
                        prev  <= cnt_s2;
                        lost  <= 1'b0;
                        state <= ST_PRIMED;
                    end
                end
                default: begin
                    if (cap_s2) begin
                        prev            <= cnt_s2;
                        rec_s3.interval <= interval_c;
                        rec_s3.error    <= err_c;
                        push_s3         <= 1'b1;
                        lost            <= 1'b0;
                        state           <= ST_TRACK;
                    end
                    if (cap_c) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt >= TO_W'(TIMEOUT - 1)) begin
                        state    <= ST_IDLE;
                        lost     <= 1'b1;
                        locked   <= 1'b0;
                        tol_cnt  <= '0;
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + TO_W'(1);
                    end
                end
            endcase
        end
    end

    // Sticky drop flag: record arrives while full and nothing is popped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (push_s3 && full && !pop_c) begin
            overflow <= 1'b1;
        end
    end

`ifdef QPSK_TIMING_STATS_EN
    // Running min/max of accepted record errors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_min <= STAT_MIN_INIT;
            err_max <= STAT_MAX_INIT;
        end else if (push_acc_c) begin
            if ($signed(rec_s3.error) < err_min) err_min <= $signed(rec_s3.error);
            if ($signed(rec_s3.error) > err_max) err_max <= $signed(rec_s3.error);
        end
    end
`endif

    qpsk_rec_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s3),
        .pop   (pop_c),
        .din   (rec_s3),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign rec_if.rec_valid    = !empty;
    assign rec_if.rec_interval = head.interval;
    assign rec_if.rec_error    = head.error;

endmodule

// File: tb/tb_qpsk_timing_tracker.sv
// Randomized self-checking bench for qpsk_timing_tracker with a
// transaction-level reference model (queue of expected records).
module tb_qpsk_timing_tracker;

    localparam int unsigned NOM        = 39062;
    localparam int unsigned TOL        = 4;
    localparam int unsigned LC         = 3;
    localparam int unsigned TB_TIMEOUT = 300;
    localparam int unsigned DEPTH      = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cic;
    logic        write;
    logic        locked, lost, overflow;
`ifdef QPSK_TIMING_STATS_EN
    logic signed [15:0] err_min, err_max;
`endif

    qpsk_timing_tracker_if rif ();

    qpsk_timing_tracker #(
        .NOMINAL    (NOM),
        .LOCK_TOL   (TOL),
        .LOCK_COUNT (LC),
        .TIMEOUT    (TB_TIMEOUT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cic_pulse_counter (cic),
        .write             (write),
        .rec_if            (rif),
        .locked            (locked),
        .lost              (lost),
        .overflow          (overflow)
`ifdef QPSK_TIMING_STATS_EN
        ,
        .err_min           (err_min),
        .err_max           (err_max)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_primed;
    logic [15:0] m_prev;
    int          m_run;
    bit          m_locked, m_lost, m_ovf;
    logic [31:0] exp_q[$];
    logic [15:0] last_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_primed = 0; m_prev = '0; m_run = 0;
        m_locked = 0; m_lost = 0; m_ovf = 0;
        exp_q.delete();
    endtask

    task automatic model_capture(input logic [15:0] cnt);
        logic [15:0] iv;
        int d;
        m_lost = 0;
        if (!m_primed) begin
            m_primed = 1;
            m_prev   = cnt;
            return;
        end
        iv     = cnt - m_prev;
        m_prev = cnt;
        d = int'(iv) - int'(NOM);
        if (d > 32767)  d = 32767;
        if (d < -32767) d = -32767;
        if (exp_q.size() < DEPTH) exp_q.push_back({iv, 16'(d)});
        else m_ovf = 1;
        if (d <= int'(TOL) && d >= -int'(TOL)) begin
            if (m_run < int'(LC)) m_run++;
        end else begin
            m_run = 0;
        end
        m_locked = (m_run >= int'(LC));
    endtask

    task automatic model_timeout();
        m_primed = 0; m_lost = 1; m_locked = 0; m_run = 0;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".valid"}, 32'(rif.rec_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            check({tag, ".head"}, {rif.rec_interval, rif.rec_error}, exp_q[0]);
        end
        check({tag, ".locked"},   32'(locked),   32'(m_locked));
        check({tag, ".lost"},     32'(lost),     32'(m_lost));
        check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    endtask

    // One capture: raise write with count stable, hold, then let the pipeline settle
    task automatic capture(input logic [15:0] cnt, input int hold);
        @(negedge clk);
        cic   = cnt;
        write = 1'b1;
        repeat (hold) @(negedge clk);
        write = 1'b0;
        repeat (4) @(negedge clk);
        cic = 16'($urandom);
        last_cnt = cnt;
        model_capture(cnt);
        check_state("cap");
    endtask

    task automatic capture_iv(input int unsigned iv);
        capture(last_cnt + 16'(iv), int'($urandom_range(1, 3)));
    endtask

    // Pop every expected record in order, then confirm the FIFO is empty
    task automatic drain();
        @(negedge clk);
        while (exp_q.size() > 0) begin
            check("drain.valid", 32'(rif.rec_valid), 32'd1);
            check("drain.rec", {rif.rec_interval, rif.rec_error}, exp_q[0]);
            void'(exp_q.pop_front());
            rif.rec_ready = 1'b1;
            @(negedge clk);
            rif.rec_ready = 1'b0;
        end
        check("drain.empty", 32'(rif.rec_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst_n = 1'b0;
        cic = '0;
        write = 1'b0;
        rif.rec_ready = 1'b0;
        last_cnt = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst.valid",    32'(rif.rec_valid),    32'd0);
        check("rst.interval", 32'(rif.rec_interval), 32'd0);
        check("rst.error",    32'(rif.rec_error),    32'd0);
        check("rst.locked",   32'(locked),           32'd0);
        check("rst.lost",     32'(lost),             32'd0);
        check("rst.overflow", 32'(overflow),         32'd0);

        // Priming capture then a nominal interval with latency measurement
        capture(16'd100, 1);
        @(negedge clk);
        cic   = 16'd39162;
        write = 1'b1;
        lat   = -1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) write = 1'b0;
            if (rif.rec_valid && lat < 0) lat = i;
        end
        last_cnt = 16'd39162;
        model_capture(16'd39162);
        check("lat.cycles", 32'(lat), 32'd3);
        check("lat.interval", 32'(rif.rec_interval), 32'd39062);
        check("lat.error", 32'(rif.rec_error), 32'd0);
        check_state("lat");
        drain();

        // Counter wrap-around and a large positive error
        capture(16'd60000, 2);
        capture(16'd33526, 2);
        check("wrap.interval", 32'(rif.rec_interval), 32'(exp_q[0][31:16]));
        drain();
        capture(16'd7592, 1);
        check("wrap.error540", 32'(rif.rec_error), 32'd540);
        check("wrap.nolock", 32'(locked), 32'd0);
        drain();

        // Lock acquisition and loss
        capture_iv(39062);
        capture_iv(39064);
        check("lock.two", 32'(locked), 32'd0);
        capture_iv(39059);
        check("lock.three", 32'(locked), 32'd1);
        capture_iv(39100);
        check("lock.drop", 32'(locked), 32'd0);
        drain();

        // Overflow: five records with no consumer
        for (int i = 0; i < 5; i++) capture_iv(NOM + $urandom_range(0, 16) - 8);
        check("ovf.flag", 32'(overflow), 32'd1);
        check("ovf.held", 32'(exp_q.size()), 32'd4);
        drain();

        // Timeout after lock
        for (int i = 0; i < 3; i++) capture_iv(NOM + $urandom_range(0, 8) - 4);
        check("to.locked", 32'(locked), 32'd1);
        drain();
        repeat (TB_TIMEOUT + 20) @(negedge clk);
        model_timeout();
        check("to.lost", 32'(lost), 32'd1);
        check_state("to");
        capture_iv(NOM);
        check("to.norec", 32'(rif.rec_valid), 32'd0);
        check("to.lostclr", 32'(lost), 32'd0);
        capture_iv(NOM);
        check("to.rec", 32'(rif.rec_valid), 32'd1);
        drain();

        // Held write level produces a single capture
        capture(last_cnt + 16'(NOM), 50);
        drain();

        // Randomized intervals, including saturating ones, with random draining
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) < 7) capture_iv(NOM + $urandom_range(0, 16) - 8);
            else capture_iv($urandom_range(0, 65535));
            if ($urandom_range(0, 3) == 0) drain();
        end
        drain();

        // Reset between the capture edge and the push
        @(negedge clk);
        cic   = last_cnt + 16'(NOM);
        write = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        write = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
        check("midrst.valid",    32'(rif.rec_valid),    32'd0);
        check("midrst.interval", 32'(rif.rec_interval), 32'd0);
        check("midrst.error",    32'(rif.rec_error),    32'd0);
        check_state("midrst");
        capture(16'd500, 1);
        capture(16'(500 + NOM + 3), 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
